// File: rtl/rsa_encryptor_if.sv
`default_nettype none
// ============================================================================
// Module      : rsa_encryptor_if
// Description : Plaintext-in / ciphertext-out valid/ready bundle for the
//               RSA encryptor, plus its busy status flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface rsa_encryptor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  plain_char;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] encrypted_char;
    logic        busy;

    // The encryptor itself: accepts characters, returns ciphertext words.
    modport slave (
        input  in_valid,
        input  plain_char,
        input  out_ready,
        output in_ready,
        output out_valid,
        output encrypted_char,
        output busy
    );

    // The producer/consumer side that feeds characters and drains results.
    modport master (
        output in_valid,
        output plain_char,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  encrypted_char,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/rsa_encryptor.sv
`default_nettype none
// ============================================================================
// Module      : rsa_encryptor
// Description : Computes c = m^E_EXP mod N_MOD for one 8-bit character using
//               right-to-left square-and-multiply with fixed EXP_WIDTH steps.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_encryptor #(
    parameter int N_MOD     = 3233,
    parameter int E_EXP     = 17,
    parameter int EXP_WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    rsa_encryptor_if.slave  bus
);

    localparam int                   C_CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [C_CNT_W-1:0]   C_LAST  = C_CNT_W'(EXP_WIDTH - 1);
    localparam logic [31:0]          C_MOD   = 32'(N_MOD);
    localparam logic [EXP_WIDTH-1:0] C_EXP   = EXP_WIDTH'(E_EXP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [15:0]          result_q, result_d;
    logic [15:0]          base_q,   base_d;
    logic [EXP_WIDTH-1:0] exp_q,    exp_d;
    logic [C_CNT_W-1:0]   count_q,  count_d;
    logic [15:0]          enc_q,    enc_d;

    logic [31:0] w_rb_prod;
    logic [31:0] w_bb_prod;
    logic [15:0] w_rb_mod;
    logic [15:0] w_bb_mod;

    // Full-width products reduced in the same cycle; operands stay < N_MOD.
    always_comb begin
        w_rb_prod = {16'b0, result_q} * {16'b0, base_q};
        w_bb_prod = {16'b0, base_q}   * {16'b0, base_q};
        w_rb_mod  = 16'(w_rb_prod % C_MOD);
        w_bb_mod  = 16'(w_bb_prod % C_MOD);
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        base_d   = base_q;
        exp_d    = exp_q;
        count_d  = count_q;
        enc_d    = enc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    result_d = 16'd1;
                    base_d   = {8'b0, bus.plain_char};
                    exp_d    = C_EXP;
                    count_d  = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // All steps run even once exp is exhausted, keeping latency fixed.
                if (exp_q[0]) begin
                    result_d = w_rb_mod;
                end
                base_d  = w_bb_mod;
                exp_d   = exp_q >> 1;
                count_d = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    enc_d   = exp_q[0] ? w_rb_mod : result_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            count_q  <= '0;
            enc_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            count_q  <= count_d;
            enc_q    <= enc_d;
        end
    end

    assign bus.in_ready       = (state_q == ST_IDLE);
    assign bus.out_valid      = (state_q == ST_DONE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.encrypted_char = enc_q;

endmodule
`default_nettype wire
